// File: rtl/pb_pkg.sv
// pb_pkg: shared widths, event entry type and round-robin pick helper for the push-button arbiter
package pb_pkg;
  localparam int PB_IDX_W = 4;
  function automatic int pb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
`ifdef PB_PRESS_EVT_EN
    logic press;
`endif
    logic [PB_IDX_W-1:0] id;
  } pb_evt_t;
  function automatic logic [5:0] rr_pick(input logic [31:0] req, input logic [4:0] ptr, input int n);
    logic [5:0] r;
    int j;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= n) j -= n;
      if (i < n && req[j[4:0]]) r = {1'b1, j[4:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/pb_event_arbiter_if.sv
// pb_event_arbiter_if: valid/ready event stream from the arbiter (master) to the consumer (slave)
interface pb_event_arbiter_if
  import pb_pkg::*;
#(
  parameter int NUM_PB = 4
);
  logic                        evt_vld;
  logic                        evt_rdy;
  logic [pb_idx_w(NUM_PB)-1:0] evt_id;
`ifdef PB_PRESS_EVT_EN
  logic                        evt_press;
  modport master(output evt_vld, evt_id, evt_press, input evt_rdy);
  modport slave(input evt_vld, evt_id, evt_press, output evt_rdy);
`else
  modport master(output evt_vld, evt_id, input evt_rdy);
  modport slave(input evt_vld, evt_id, output evt_rdy);
`endif
endinterface

// File: rtl/pb_debounce.sv
// pb_debounce: 2-flop synchronizer and counter debounce for one button; upd_o pulses on the edge the level flips
module pb_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic level_o,
  output logic upd_o
);
  localparam int CW = $clog2(DB_CYCLES);
  logic          ff1_q, ff2_q, lvl_q, mis;
  logic [CW-1:0] cnt_q;
  assign mis     = ff2_q ^ lvl_q;
  assign upd_o   = mis & (cnt_q == CW'(DB_CYCLES - 1));
  assign level_o = lvl_q;
  // synchronize, count consecutive mismatch cycles, adopt the new level once it has held long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      ff1_q <= pb_i;
      ff2_q <= ff1_q;
      lvl_q <= upd_o ? ff2_q : lvl_q;
      cnt_q <= (mis & !upd_o) ? cnt_q + CW'(1) : '0;
    end
  end
endmodule

// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter: debounced button edges round-robin arbitrated into an event FIFO; PB_PRESS_EVT_EN adds press events
module pb_event_arbiter
  import pb_pkg::*;
#(
  parameter int NUM_PB     = 4,
  parameter int DB_CYCLES  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] PB_i,
  output logic [NUM_PB-1:0] pb_level_o,
  output logic              overflow_o,
  pb_event_arbiter_if.master evt
);
`ifdef PB_PRESS_EVT_EN
  localparam int NR = 2 * NUM_PB;
`else
  localparam int NR = NUM_PB;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = pb_idx_w(NUM_PB);
  logic [NUM_PB-1:0] upd;
  logic [NR-1:0]     set_w, grant, pend_q, pend_d;
  logic [5:0]        pick;
  logic [4:0]        rr_q, rr_d;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              pop, push, ovf_q;
  pb_evt_t           mem_q [FIFO_DEPTH];
  pb_evt_t           push_evt, head;
  for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .pb_i   (PB_i[i]),
      .level_o(pb_level_o[i]),
      .upd_o  (upd[i])
    );
`ifdef PB_PRESS_EVT_EN
    assign set_w[2*i]   = upd[i] & pb_level_o[i];
    assign set_w[2*i+1] = upd[i] & ~pb_level_o[i];
`else
    assign set_w[i] = upd[i] & ~pb_level_o[i];
`endif
  end
  assign pick   = rr_pick(32'(pend_q), rr_q, NR);
  assign pop    = evt.evt_vld & evt.evt_rdy;
  assign push   = pick[5] & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop);
  assign grant  = push ? NR'(1) << pick[4:0] : '0;
  assign pend_d = (pend_q & ~grant) | set_w;
  assign rr_d   = push ? ((pick[4:0] == 5'(NR - 1)) ? 5'd0 : pick[4:0] + 5'd1) : rr_q;
  assign head   = mem_q[rd_q];
  assign evt.evt_vld = cnt_q != '0;
  assign evt.evt_id  = evt.evt_vld ? head.id[IW-1:0] : '0;
`ifdef PB_PRESS_EVT_EN
  assign evt.evt_press = evt.evt_vld & head.press;
`endif
  assign overflow_o = ovf_q;
  // build the FIFO entry for the granted requester (press/release pairs interleave per button)
  always_comb begin
    push_evt = '0;
`ifdef PB_PRESS_EVT_EN
    push_evt.id    = pick[4:1];
    push_evt.press = ~pick[0];
`else
    push_evt.id    = pick[3:0];
`endif
  end
  // pending vector, round-robin pointer, sticky overflow and event FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      rr_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      ovf_q  <= ovf_q | (|(set_w & pend_q & ~grant));
      wr_q   <= wr_q + AW'(push);
      rd_q   <= rd_q + AW'(pop);
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) mem_q[wr_q] <= push_evt;
    end
  end
endmodule

// File: tb/tb_pb_event_arbiter.sv
// tb_pb_event_arbiter: directed stimulus with an event-level reference model checked every cycle
module tb_pb_event_arbiter;
  import pb_pkg::*;
  localparam int N = 4, DB = 16, FD = 4;
`ifdef PB_PRESS_EVT_EN
  localparam int NR = 2 * N;
`else
  localparam int NR = N;
`endif
  logic clk = 0, rst = 1;
  logic [N-1:0] PB = '1, lvl_o;
  logic ovf_o;
  pb_event_arbiter_if #(.NUM_PB(N)) bus ();
  pb_event_arbiter #(.NUM_PB(N), .DB_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .PB_i(PB), .pb_level_o(lvl_o), .overflow_o(ovf_o), .evt(bus.master)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit live = 0;
  int s1 [N], s2 [N], lvl [N], run_len [N];
  bit pend [NR];
  int rr;
  int q [$];
  bit m_ovf;
  logic [31:0] exp_lvl;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model();
    int g, r;
    bit pop, ev;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        s1[i] = 1; s2[i] = 1; lvl[i] = 1; run_len[i] = 0;
      end
      for (int k = 0; k < NR; k++) pend[k] = 0;
      rr = 0; q.delete(); m_ovf = 0;
      return;
    end
    pop = q.size() > 0 && bus.evt_rdy;
    g = -1;
    if (q.size() < FD || pop)
      for (int k = 0; k < NR; k++) if (g < 0 && pend[(rr + k) % NR]) g = (rr + k) % NR;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(g); pend[g] = 0; rr = (g + 1) % NR;
    end
    for (int i = 0; i < N; i++) begin
      ev = 0;
      if (s2[i] != lvl[i]) run_len[i]++; else run_len[i] = 0;
      if (run_len[i] == DB) begin
        lvl[i] = s2[i]; run_len[i] = 0; ev = 1;
      end
      s2[i] = s1[i]; s1[i] = int'(PB[i]);
`ifdef PB_PRESS_EVT_EN
      r = 2 * i + lvl[i];
`else
      r = i;
      if (lvl[i] == 0) ev = 0;
`endif
      if (ev) begin
        if (pend[r]) m_ovf = 1; else pend[r] = 1;
      end
    end
  endtask
  always @(negedge clk) if (live) begin
    exp_lvl = 0;
    for (int i = 0; i < N; i++) exp_lvl[i] = lvl[i][0];
    chk("pb_level", 32'(lvl_o), exp_lvl);
    chk("evt_vld", 32'(bus.evt_vld), 32'(q.size() > 0));
    chk("evt_id", 32'(bus.evt_id), q.size() > 0 ? 32'(q[0] / (NR / N)) : 0);
`ifdef PB_PRESS_EVT_EN
    chk("evt_press", 32'(bus.evt_press), q.size() > 0 ? 32'(q[0] % 2 == 0) : 0);
`endif
    chk("overflow", 32'(ovf_o), 32'(m_ovf));
  end
  task automatic step();
    @(posedge clk);
    model();
    live = 1;
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic hold(input logic [N-1:0] m);
    PB = PB & ~m; run(20);
    PB = PB | m; run(20);
  endtask
  initial begin
    bus.evt_rdy = 0;
    run(2); rst = 0;
    run(50);
    chk("t1_vld", 32'(bus.evt_vld), 0);
    chk("t1_lvl", 32'(lvl_o), 32'hF);
    chk("t1_ovf", 32'(ovf_o), 0);
    bus.evt_rdy = 1; PB[2] = 0; run(20);
    bus.evt_rdy = 0; PB[2] = 1;
    run(18);
    chk("t2_vld_early", 32'(bus.evt_vld), 0);
    run(1);
    chk("t2_vld", 32'(bus.evt_vld), 1);
    chk("t2_id", 32'(bus.evt_id), 2);
    bus.evt_rdy = 1; run(1);
    chk("t2_pop", 32'(bus.evt_vld), 0);
    PB[1] = 0; run(10); PB[1] = 1; run(40);
    chk("t3_lvl", 32'(lvl_o), 32'hF);
    chk("t3_vld", 32'(bus.evt_vld), 0);
    rst = 1; run(1); rst = 0;
`ifndef PB_PRESS_EVT_EN
    PB = 4'b0110; run(20);
    bus.evt_rdy = 0; PB = 4'b1111; run(20);
    chk("t4_first", 32'(bus.evt_id), 0);
    bus.evt_rdy = 1; run(1);
    chk("t4_second", 32'(bus.evt_id), 3);
    chk("t4_vld", 32'(bus.evt_vld), 1);
    run(1);
    chk("t4_empty", 32'(bus.evt_vld), 0);
    bus.evt_rdy = 0;
    hold(4'b0001); hold(4'b0010); hold(4'b0100); hold(4'b1000);
    chk("t5_head", 32'(bus.evt_id), 0);
    hold(4'b0001);
    chk("t5_ovf_pend", 32'(ovf_o), 0);
    bus.evt_rdy = 1; run(1); bus.evt_rdy = 0;
    chk("t5_head2", 32'(bus.evt_id), 1);
    chk("t5_ovf_push", 32'(ovf_o), 0);
    hold(4'b0010); hold(4'b0010);
    chk("t5_ovf_set", 32'(ovf_o), 1);
    run(30);
    chk("t5_ovf_sticky", 32'(ovf_o), 1);
    rst = 1; run(1); rst = 0;
    chk("t6_vld", 32'(bus.evt_vld), 0);
    chk("t6_ovf", 32'(ovf_o), 0);
    run(40);
    chk("t6_stale", 32'(bus.evt_vld), 0);
`else
    bus.evt_rdy = 0;
    hold(4'b0010);
    chk("t6_press_id", 32'(bus.evt_id), 1);
    chk("t6_press", 32'(bus.evt_press), 1);
    bus.evt_rdy = 1; run(1);
    chk("t6_rel_id", 32'(bus.evt_id), 1);
    chk("t6_rel", 32'(bus.evt_press), 0);
    run(1);
    chk("t6_empty", 32'(bus.evt_vld), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
